// File: rtl/program_fetch_ctrl_pkg.sv
// Shared types and constants for the program fetch controller.
//   ADDR_W / WORD_W  : fetch address and ROM word widths
//   FETCH_STRIDE     : bytes advanced per fetch
//   state_e          : fetch FSM states
//   fetch_entry_t    : one prefetch queue entry {pc, word}
package program_fetch_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 32;
  localparam logic [ADDR_W-1:0] FETCH_STRIDE = 16'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + FETCH_STRIDE;
  endfunction

endpackage

// File: rtl/program_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the program ROM and the consumer.
//   enable                    : fetch issue enable
//   rom_addr / rom_data       : ROM request address and registered read data
//   redirect / redirect_addr  : flush and restart request
//   instr_valid/ready/data/pc : instruction output handshake
// master = fetch controller side, slave = ROM/consumer side.
interface program_fetch_ctrl_if;
  import program_fetch_ctrl_pkg::*;

  logic              enable;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic [WORD_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    input  enable, rom_data, redirect, redirect_addr, instr_ready,
    output rom_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output enable, rom_data, redirect, redirect_addr, instr_ready,
    input  rom_addr, instr_valid, instr_data, instr_pc
  );

endinterface

// File: rtl/program_fetch_ctrl_fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, word} prefetch entries.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : empty the queue; overrides push and pop in the same cycle
//   push      : write wr_entry at the tail
//   pop       : drop the head (ignored when empty)
//   wr_entry  : entry to write
//   head      : current head entry (meaningful only when count != 0)
//   count     : number of valid entries, 0..DEPTH
module fetch_queue
  import program_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/program_fetch_ctrl.sv
// program_fetch_ctrl: credit-based instruction prefetcher for a program ROM
// with one cycle of read latency.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : program_fetch_ctrl_if.master (ROM port, redirect, output handshake)
// Parameters:
//   RESET_PC : first fetch address after reset
//   DEPTH    : prefetch queue entries (power of two, 2..8)
// A fetch is issued only while queued + in-flight words fit in the queue,
// so the ROM return can always be pushed. Redirects toggle an epoch bit so
// a word fetched before the redirect is recognised and dropped.
module program_fetch_ctrl
  import program_fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4
) (
  input logic                  clk,
  input logic                  rst,
  program_fetch_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              epoch;
  logic              inflight;
  logic              inflight_epoch;
  logic [ADDR_W-1:0] inflight_pc;

  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      q_wr;
  logic              q_push;
  logic              q_pop;

  logic [CNT_W:0]    used;
  logic              issue;
  logic              head_valid;
  logic [WORD_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_pc;

  // ---------------------------------------------------------------- issue
  assign used  = {1'b0, q_count} + {{CNT_W{1'b0}}, inflight};
  assign issue = (state == RUN) & ~bus.redirect & (used < (CNT_W+1)'(DEPTH));

  assign bus.rom_addr = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= bus.enable ? RUN : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= '0;
    end else begin
      // ROM answers exactly one cycle after an issue, so inflight is a
      // single-cycle flag rather than a counter.
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= fetch_pc;
        inflight_epoch <= epoch;
      end
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_addr;
        epoch    <= ~epoch;
      end else if (issue) begin
        fetch_pc <= next_pc(fetch_pc);
      end
    end
  end

  // ---------------------------------------------------------------- queue
  // The epoch test drops a return from before the last redirect; the
  // redirect term covers a return landing in the redirect cycle itself.
  assign q_push = inflight & (inflight_epoch == epoch) & ~bus.redirect;
  assign q_pop  = head_valid & bus.instr_ready & ~bus.redirect;
  assign q_wr   = '{pc: inflight_pc, word: bus.rom_data};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect),
    .push     (q_push),
    .pop      (q_pop),
    .wr_entry (q_wr),
    .head     (q_head),
    .count    (q_count)
  );

  // ---------------------------------------------------------------- output
  assign head_valid      = (q_count != '0);
  assign bus.instr_valid = head_valid;
  assign bus.instr_data  = head_valid ? q_head.word : hold_data;
  assign bus.instr_pc    = head_valid ? q_head.pc   : hold_pc;

  // Tracks what was last shown so the outputs freeze once the queue drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_pc   <= '0;
    end else begin
      hold_data <= bus.instr_data;
      hold_pc   <= bus.instr_pc;
    end
  end

endmodule
